queue_arbiter: RTL and testbench
================================

QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, meaning entries per input queue; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port inputs[0:`REN-1], input, `PL bits each, one packet per port; bit 0 is valid, bits 1..`CS are dest X, bits `CS+1..2*`CS are dest Y.
REQ-005 SHALL have port availability_out[0:`REN-1], output, 1 bit each, high when that port's queue can accept a packet this cycle.
REQ-006 SHALL have port shift_signals[0:`REN-1], input, 1 bit each, pop request from the routing stage.
REQ-007 SHALL have port from_arbiter, output, `PL bits, the selected head packet presented to the routing stage.
REQ-008 SHALL have port shift, output, `REN_B bits, the index of the queue currently presented.

Function
REQ-009 SHALL keep one FIFO per port, depth QUEUE_DEPTH, with packets in arrival order.
REQ-010 SHALL push inputs[i] into queue i when inputs[i][0]=1 and availability_out[i]=1 in the same cycle.
REQ-011 SHALL drive availability_out[i] = (count_i < QUEUE_DEPTH), evaluated before any same-cycle pop; a full queue with a simultaneous pop still refuses the push.
REQ-012 SHALL silently drop a valid packet offered while availability_out[i]=0; queue contents unchanged.
REQ-013 SHALL hold a registered round-robin pointer ptr in 0..`REN-1 and drive shift = ptr.
REQ-014 SHALL drive from_arbiter combinationally: the head of queue ptr when it is non-empty, otherwise all zeros (valid bit 0).
REQ-015 SHALL pop queue ptr when shift_signals[ptr]=1 and queue ptr is non-empty; shift_signals[j] for j != ptr is ignored.
REQ-016 SHALL allow a push and a pop on the same non-full queue in one cycle, leaving count unchanged.
REQ-017 SHALL make a packet pushed in cycle N visible at from_arbiter no earlier than cycle N+1; there is no input-to-output bypass.
REQ-018 SHALL advance ptr every cycle in which queue ptr pops, or queue ptr is empty; otherwise ptr holds while the head is blocked.
REQ-019 SHALL wrap ptr from `REN-1 to 0.
REQ-020 SHALL wrap FIFO read and write indices modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH with no overflow.

Reset
REQ-021 SHALL, while rst_n=0 at a clock edge, empty all queues, set ptr=0, and clear all read/write indices and counts.
REQ-022 SHALL, in the cycle after reset, drive from_arbiter=0, shift=0 and availability_out all 1.
REQ-023 SHALL let a reset mid-operation discard all queued packets; no pop or push takes effect in that cycle.

Configuration
REQ-024 SHALL, with macro ARBITER_SKIP_EMPTY_EN defined, advance ptr to the first non-empty queue cyclically after ptr, judged on post-update occupancy; if no other queue is non-empty, ptr holds.
REQ-025 SHALL, without ARBITER_SKIP_EMPTY_EN, advance ptr to (ptr+1) mod `REN whenever REQ-018 calls for an advance.

Structure
REQ-026 SHALL take `PL, `CS, `REN and `REN_B from the shared router.svh header; no new widths are defined locally.
REQ-027 SHALL implement each FIFO as one sub-module, router_queue (parameter QUEUE_DEPTH), instantiated `REN times.
REQ-028 SHALL place the pointer and next-pointer search logic in queue_arbiter itself.

Verification
REQ-029 SHALL cover reset: after rst_n low for 2 cycles, expect availability_out=11111, from_arbiter=0, shift=0.
REQ-030 SHALL cover a single packet: push valid packet dest (2,1) on port 3 with ptr=0 and skip-empty on; expect the next cycle ptr=3 and from_arbiter equal to the packet; with shift_signals[3]=1, queue 3 empties and ptr holds at 3.
REQ-031 SHALL cover full/drop: push 5 packets back-to-back on port 1 with no pops; expect availability_out[1]=0 after the 4th push, the 5th packet dropped, and later pops returning packets 1..4 in order.
REQ-032 SHALL cover blocking: fill queues 0 and 2 and hold shift_signals low for 10 cycles; expect ptr stuck at 0 and from_arbiter stable.
REQ-033 SHALL cover fairness: keep queues 0..4 non-empty and pop every cycle; expect shift to sequence 0,1,2,3,4,0 with both macro settings.
REQ-034 SHALL cover reset mid-operation: assert rst_n low while queues hold 3 packets each; expect all empty afterwards and no stale packet at from_arbiter.

Source files
------------

// File: rtl/queue_arbiter_pkg.sv
// queue_arbiter_pkg: shared router widths (router.svh contents) and pointer helper
// Macros: `CS coordinate bits, `PL packet bits, `REN ports, `REN_B port index bits.
// Skip-empty pointer advance in queue_arbiter is enabled by defining ARBITER_SKIP_EMPTY_EN.
`ifndef ROUTER_SVH
`define ROUTER_SVH
`define CS 3
`define PL (2*`CS+1)
`define REN 5
`define REN_B 3
`endif
package queue_arbiter_pkg;
  localparam int CS = `CS;
  localparam int PL = `PL;
  localparam int REN = `REN;
  localparam int REN_B = `REN_B;
  typedef logic [PL-1:0] pkt_t;
  typedef logic [REN_B-1:0] idx_t;
  // cyclic index p+k over REN ports, k in 0..REN-1
  function automatic idx_t ptr_add(idx_t p, int k);
    int s;
    s = int'(p) + k;
    return idx_t'(s >= REN ? s - REN : s);
  endfunction
endpackage

// File: rtl/queue_arbiter_queue.sv
// router_queue: per-port packet FIFO of QUEUE_DEPTH entries
// Ports: clk, rst_n (sync, active-low), push_i/data_i write side, pop_i read side,
//        head_o oldest entry, avail_o not-full, empty_o, empty_nxt_o (skip-empty builds only).
module router_queue
  import queue_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  pkt_t data_i,
  output pkt_t head_o,
  output logic avail_o,
  output logic empty_o
`ifdef ARBITER_SKIP_EMPTY_EN
  ,
  output logic empty_nxt_o
`endif
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);
  pkt_t mem_q [QUEUE_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // fullness is judged before any same-cycle pop, so a full queue refuses pushes
  assign avail_o = cnt_q < FULL;
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && avail_o;
  assign do_pop = pop_i && !empty_o;
  assign rd_d = do_pop ? rd_q + AW'(1) : rd_q;
  assign wr_d = do_push ? wr_q + AW'(1) : wr_q;
  assign cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign head_o = mem_q[rd_q];
`ifdef ARBITER_SKIP_EMPTY_EN
  assign empty_nxt_o = cnt_d == '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (rst_n && do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/queue_arbiter.sv
// queue_arbiter: per-port input FIFOs with a round-robin head selector for the routing stage
// Ports: clk, rst_n (sync, active-low), inputs[] packets (bit 0 valid), availability_out[] not-full,
//        shift_signals[] pop requests, from_arbiter selected head (0 when empty), shift selected index.
// Define ARBITER_SKIP_EMPTY_EN to jump the pointer straight to the next occupied queue.
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PL-1:0]    inputs [0:REN-1],
  output logic             availability_out [0:REN-1],
  input  logic             shift_signals [0:REN-1],
  output logic [PL-1:0]    from_arbiter,
  output logic [REN_B-1:0] shift
);
  pkt_t head [REN];
  logic [REN-1:0] empty, pop;
`ifdef ARBITER_SKIP_EMPTY_EN
  logic [REN-1:0] empty_nxt;
`endif
  idx_t ptr_q, ptr_d;
  logic adv;
  for (genvar i = 0; i < REN; i++) begin : g_q
    // only the presented queue may pop; other shift requests are ignored
    assign pop[i] = shift_signals[i] && ptr_q == idx_t'(i);
    router_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_q (
      .clk(clk),
      .rst_n(rst_n),
      .push_i(inputs[i][0]),
      .pop_i(pop[i]),
      .data_i(inputs[i]),
      .head_o(head[i]),
      .avail_o(availability_out[i]),
      .empty_o(empty[i])
`ifdef ARBITER_SKIP_EMPTY_EN
      ,
      .empty_nxt_o(empty_nxt[i])
`endif
    );
  end
  // move on after a pop or past an empty queue; a blocked head holds the pointer
  assign adv = empty[ptr_q] || shift_signals[ptr_q];
  assign from_arbiter = empty[ptr_q] ? '0 : head[ptr_q];
  assign shift = ptr_q;
  always_comb begin
    ptr_d = ptr_q;
`ifdef ARBITER_SKIP_EMPTY_EN
    if (adv)
      for (int k = REN - 1; k >= 1; k--)
        if (!empty_nxt[ptr_add(ptr_q, k)]) ptr_d = ptr_add(ptr_q, k);
`else
    if (adv) ptr_d = ptr_add(ptr_q, 1);
`endif
  end
  always_ff @(posedge clk) ptr_q <= !rst_n ? '0 : ptr_d;
endmodule

// File: tb/tb_queue_arbiter.sv
// tb_queue_arbiter: directed stimulus with a scoreboard of expected pops checked by a monitor
module tb_queue_arbiter;
`ifdef ARBITER_SKIP_EMPTY_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif
  typedef struct packed {
    logic [2:0] port;
    logic [6:0] pkt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] inputs [0:4];
  logic availability_out [0:4];
  logic shift_signals [0:4];
  logic [6:0] from_arbiter;
  logic [2:0] shift;
  logic [4:0] sh, av;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  queue_arbiter #(.QUEUE_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inputs(inputs),
    .availability_out(availability_out),
    .shift_signals(shift_signals),
    .from_arbiter(from_arbiter),
    .shift(shift)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 5; i++) begin
      shift_signals[i] = sh[i];
      av[i] = availability_out[i];
    end

  function automatic logic [6:0] mk(input int x, input int y);
    return {y[2:0], x[2:0], 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic expect_push(input int p, input logic [6:0] d);
    sb.push_back('{port: 3'(p), pkt: d});
  endtask

  task automatic wait_shift(input int t, output int k);
    k = 0;
    @(negedge clk);
    while (int'(shift) != t && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wait_shift", int'(shift), t);
  endtask

  task automatic drain(input string n);
    int k = 0;
    step();
    sh = '1;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1 sh = '0;
    chk(n, sb.size(), 0);
  endtask

  // every real pop is matched against the oldest expected packet for that port
  always @(negedge clk) begin
    int idx;
    if (rst_n && from_arbiter[0] && sh[shift]) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && int'(sb[i].port) == int'(shift)) idx = i;
      total++;
      if (idx < 0) begin
        bad++;
        $display("FAIL pop_unexpected: port %0d got %0h want no packet", shift, from_arbiter);
      end else begin
        if (sb[idx].pkt !== from_arbiter) begin
          bad++;
          $display("FAIL pop_data: port %0d got %0h want %0h", shift, from_arbiter, sb[idx].pkt);
        end
        sb.delete(idx);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    sh = '0;
    for (int p = 0; p < 5; p++) inputs[p] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    inputs[3] = mk(2, 1);
    expect_push(3, mk(2, 1));
    @(negedge clk);
    chk("rst_avail", int'(av), 'h1f);
    chk("rst_from", int'(from_arbiter), 0);
    chk("rst_shift", int'(shift), 0);
    step();
    inputs[3] = '0;
    wait_shift(3, k);
    chk("single_latency", k, SKIP != 0 ? 0 : 2);
    chk("single_head", int'(from_arbiter), int'(mk(2, 1)));
    step();
    sh[3] = 1'b1;
    step();
    sh[3] = 1'b0;
    @(negedge clk);
    chk("single_empty", int'(from_arbiter), 0);
    chk("single_ptr", int'(shift), SKIP != 0 ? 3 : 4);
    chk("single_sb", sb.size(), 0);

    for (int n = 1; n <= 5; n++) begin
      step();
      inputs[1] = mk(n, n + 2);
      @(negedge clk);
      chk("full_avail", int'(av[1]), n <= 4 ? 1 : 0);
      if (n <= 4) expect_push(1, mk(n, n + 2));
    end
    step();
    inputs[1] = '0;
    drain("full_drain");
    @(negedge clk);
    chk("full_avail_after", int'(av[1]), 1);

    step();
    inputs[0] = mk(1, 1);
    expect_push(0, mk(1, 1));
    step();
    inputs[0] = mk(2, 2);
    expect_push(0, mk(2, 2));
    step();
    inputs[0] = '0;
    wait_shift(0, k);
    step();
    inputs[2] = mk(3, 3);
    expect_push(2, mk(3, 3));
    step();
    inputs[2] = mk(4, 4);
    expect_push(2, mk(4, 4));
    step();
    inputs[2] = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("block_hold", int'({shift, from_arbiter}), int'({3'd0, mk(1, 1)}));
    end
    drain("block_drain");

    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb.delete();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 5; p++) begin
        inputs[p] = mk(p, r);
        expect_push(p, mk(p, r));
      end
      step();
    end
    for (int p = 0; p < 5; p++) inputs[p] = '0;
    step();
    sh = '1;
    wait_shift(0, k);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("fair_seq", int'(shift), j % 5);
    end
    drain("fair_drain");

    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 5; p++) begin
        inputs[p] = mk(p, r + 4);
        expect_push(p, mk(p, r + 4));
      end
      step();
    end
    for (int p = 0; p < 5; p++) inputs[p] = '0;
    @(negedge clk);
    chk("mid_avail", int'(av), 'h1f);
    step();
    rst_n = 1'b0;
    sh = '1;
    for (int p = 0; p < 5; p++) inputs[p] = mk(7, 7);
    step();
    rst_n = 1'b1;
    sh = '0;
    for (int p = 0; p < 5; p++) inputs[p] = '0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_avail", int'(av), 'h1f);
    chk("mid_rst_from", int'(from_arbiter), 0);
    chk("mid_rst_shift", int'(shift), 0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("mid_no_stale", int'(from_arbiter), 0);
    end
    step();
    inputs[4] = mk(5, 6);
    expect_push(4, mk(5, 6));
    step();
    inputs[4] = '0;
    drain("mid_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
